// File: rtl/id_ex_operand_stage_pkg.sv
// Shared pipeline constants and types for the ID/EX operand stage.
package id_ex_operand_stage_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned IMM_W     = 21;
    localparam int unsigned SEL_W     = 3;

    // Operand-handler select codes carried through the stage untouched.
    typedef enum logic [SEL_W-1:0] {
        SEL_RB_PASS  = 3'd0,
        SEL_IMM11    = 3'd1,
        SEL_IMM14    = 3'd2,
        SEL_IMM21_L  = 3'd3,
        SEL_SHR_LOG  = 3'd4,
        SEL_SHR_ARI  = 3'd5,
        SEL_SHL      = 3'd6,
        SEL_ZERO     = 3'd7
    } sel_t;

    // One operand bundle as held by the stage.
    typedef struct packed {
        logic [DATA_W-1:0]    ra;
        logic [DATA_W-1:0]    rb;
        logic [REG_IDX_W-1:0] ra_idx;
        logic [REG_IDX_W-1:0] rb_idx;
        logic [IMM_W-1:0]     imm;
        sel_t                 sel;
    } bundle_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side bundle, producer forwarding buses and execute-side handshake.
interface id_ex_operand_stage_if;
    import id_ex_operand_stage_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_ra;
    logic [DATA_W-1:0]    in_rb;
    logic [REG_IDX_W-1:0] in_ra_idx;
    logic [REG_IDX_W-1:0] in_rb_idx;
    logic [IMM_W-1:0]     in_i;
    logic [SEL_W-1:0]     in_s;

    logic                 ex_we;
    logic [REG_IDX_W-1:0] ex_rd;
    logic [DATA_W-1:0]    ex_data;
    logic                 ex_is_load;
    logic                 wb_we;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [DATA_W-1:0]    wb_data;
    logic                 flush;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    RA;
    logic [DATA_W-1:0]    RB;
    logic [IMM_W-1:0]     I;
    logic [SEL_W-1:0]     S;

    modport master (
        output in_valid, in_ra, in_rb, in_ra_idx, in_rb_idx, in_i, in_s,
        output ex_we, ex_rd, ex_data, ex_is_load, wb_we, wb_rd, wb_data, flush,
        output out_ready,
        input  in_ready, out_valid, RA, RB, I, S
    );

    modport slave (
        input  in_valid, in_ra, in_rb, in_ra_idx, in_rb_idx, in_i, in_s,
        input  ex_we, ex_rd, ex_data, ex_is_load, wb_we, wb_rd, wb_data, flush,
        input  out_ready,
        output in_ready, out_valid, RA, RB, I, S
    );

endinterface

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Per-operand bypass select: EX (non-load) beats WB beats register file;
// register 0 never forwards. A load match in EX flags the operand pending.
module fwd_select
    import id_ex_operand_stage_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [DATA_W-1:0]    rf_data,
    input  logic                 ex_we,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [DATA_W-1:0]    ex_data,
    input  logic                 ex_is_load,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    output logic [DATA_W-1:0]    fwd_data,
    output logic                 fwd_hit,
    output logic                 load_hit
);

    // Priority compare against the two producers.
    always_comb begin
        fwd_data = rf_data;
        fwd_hit  = 1'b0;
        load_hit = 1'b0;
        if (FWD_EN && (idx != '0)) begin
            if (ex_we && (ex_rd == idx)) begin
                if (ex_is_load) begin
                    load_hit = 1'b1;
                end else begin
                    fwd_data = ex_data;
                    fwd_hit  = 1'b1;
                end
            end
            if (!fwd_hit && wb_we && (wb_rd == idx)) begin
                fwd_data = wb_data;
                fwd_hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// One-entry ID/EX operand register with operand bypass and load-use hold.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    id_ex_operand_stage_if.slave    bus
);

    bundle_t              held;
    logic                 full;
    logic                 pend_a;
    logic                 pend_b;

    logic                 capture;
    logic                 release_now;
    logic                 refresh;
    logic                 use_incoming;
    logic [REG_IDX_W-1:0] a_idx;
    logic [REG_IDX_W-1:0] b_idx;
    logic [DATA_W-1:0]    a_src;
    logic [DATA_W-1:0]    b_src;
    logic [DATA_W-1:0]    a_fwd;
    logic [DATA_W-1:0]    b_fwd;
    logic                 a_hit;
    logic                 b_hit;
    logic                 a_load;
    logic                 b_load;

    assign bus.out_valid = full && !pend_a && !pend_b;
    assign bus.in_ready  = !full || (bus.out_valid && bus.out_ready);
    assign bus.RA        = held.ra;
    assign bus.RB        = held.rb;
    assign bus.I         = held.imm;
    assign bus.S         = held.sel;

    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;
    assign release_now  = bus.out_valid && bus.out_ready;
    // A held bundle is refreshed only while it is stalled on a pending
    // operand, so a presented (valid) bundle never changes under the consumer.
    assign refresh      = full && !bus.out_valid;
    assign use_incoming = !full || release_now;

    // The same compare logic serves capture (incoming operands) and refresh
    // (stored operands); only the index/data source differs.
    always_comb begin
        a_idx = use_incoming ? bus.in_ra_idx : held.ra_idx;
        b_idx = use_incoming ? bus.in_rb_idx : held.rb_idx;
        a_src = use_incoming ? bus.in_ra     : held.ra;
        b_src = use_incoming ? bus.in_rb     : held.rb;
    end

    fwd_select #(.FWD_EN(FWD_EN)) u_fwd_a (
        .idx        (a_idx),
        .rf_data    (a_src),
        .ex_we      (bus.ex_we),
        .ex_rd      (bus.ex_rd),
        .ex_data    (bus.ex_data),
        .ex_is_load (bus.ex_is_load),
        .wb_we      (bus.wb_we),
        .wb_rd      (bus.wb_rd),
        .wb_data    (bus.wb_data),
        .fwd_data   (a_fwd),
        .fwd_hit    (a_hit),
        .load_hit   (a_load)
    );

    fwd_select #(.FWD_EN(FWD_EN)) u_fwd_b (
        .idx        (b_idx),
        .rf_data    (b_src),
        .ex_we      (bus.ex_we),
        .ex_rd      (bus.ex_rd),
        .ex_data    (bus.ex_data),
        .ex_is_load (bus.ex_is_load),
        .wb_we      (bus.wb_we),
        .wb_rd      (bus.wb_rd),
        .wb_data    (bus.wb_data),
        .fwd_data   (b_fwd),
        .fwd_hit    (b_hit),
        .load_hit   (b_load)
    );

    // Occupancy, pending flags and held operands: reset > flush > capture > release > refresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            full   <= 1'b0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            held   <= '0;
        end else if (bus.flush) begin
            full   <= 1'b0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else if (capture) begin
            full        <= 1'b1;
            held.ra     <= a_fwd;
            held.rb     <= b_fwd;
            held.ra_idx <= bus.in_ra_idx;
            held.rb_idx <= bus.in_rb_idx;
            held.imm    <= bus.in_i;
            held.sel    <= sel_t'(bus.in_s);
            pend_a      <= a_load;
            pend_b      <= b_load;
        end else if (release_now) begin
            full   <= 1'b0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else if (refresh) begin
            held.ra <= a_fwd;
            held.rb <= b_fwd;
            if (a_load) begin
                pend_a <= 1'b1;
            end else if (a_hit) begin
                pend_a <= 1'b0;
            end
            if (b_load) begin
                pend_b <= 1'b1;
            end else if (b_hit) begin
                pend_b <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: behavioural model checked every cycle plus
// hand-computed directed expectations.
module tb_id_ex_operand_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage #(.FWD_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_known = 0;
    bit          m_full;
    bit          m_wait_a, m_wait_b;
    logic [31:0] m_ra, m_rb;
    logic [4:0]  m_ra_idx, m_rb_idx;
    logic [20:0] m_i;
    logic [2:0]  m_s;

    // Newest available value of register idx given its register-file value.
    function automatic logic [31:0] newest(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (bus.ex_we && !bus.ex_is_load && bus.ex_rd == idx) return bus.ex_data;
        if (bus.wb_we && bus.wb_rd == idx) return bus.wb_data;
        return rf;
    endfunction

    function automatic bit load_in_flight(input logic [4:0] idx);
        return idx != 0 && bus.ex_we && bus.ex_is_load && bus.ex_rd == idx;
    endfunction

    function automatic bit value_arrives(input logic [4:0] idx);
        if (idx == 0) return 0;
        return (bus.ex_we && !bus.ex_is_load && bus.ex_rd == idx) || (bus.wb_we && bus.wb_rd == idx);
    endfunction

    always @(posedge clk) begin
        bit ov, ir;
        if (reset) begin
            m_known = 1; m_full = 0; m_wait_a = 0; m_wait_b = 0;
            m_ra = 0; m_rb = 0; m_i = 0; m_s = 0; m_ra_idx = 0; m_rb_idx = 0;
        end else if (m_known) begin
            ov = m_full && !m_wait_a && !m_wait_b;
            ir = !m_full || (ov && bus.out_ready);
            if (bus.flush) begin
                m_full = 0; m_wait_a = 0; m_wait_b = 0;
            end else if (bus.in_valid && ir) begin
                m_full = 1;
                m_ra = newest(bus.in_ra_idx, bus.in_ra);
                m_rb = newest(bus.in_rb_idx, bus.in_rb);
                m_ra_idx = bus.in_ra_idx; m_rb_idx = bus.in_rb_idx;
                m_i = bus.in_i; m_s = bus.in_s;
                m_wait_a = load_in_flight(bus.in_ra_idx);
                m_wait_b = load_in_flight(bus.in_rb_idx);
            end else if (ov && bus.out_ready) begin
                m_full = 0;
            end else if (m_full && !ov) begin
                // stalled bundle keeps picking up fresher producer results
                m_ra = newest(m_ra_idx, m_ra);
                m_rb = newest(m_rb_idx, m_rb);
                if (load_in_flight(m_ra_idx)) m_wait_a = 1;
                else if (value_arrives(m_ra_idx)) m_wait_a = 0;
                if (load_in_flight(m_rb_idx)) m_wait_b = 1;
                else if (value_arrives(m_rb_idx)) m_wait_b = 0;
            end
        end
    end

    // Compare DUT against model every cycle once the model is initialised.
    always @(negedge clk) begin
        bit ov;
        if (m_known) begin
            ov = m_full && !m_wait_a && !m_wait_b;
            chk("model out_valid", 32'(bus.out_valid), 32'(ov));
            chk("model in_ready", 32'(bus.in_ready), 32'(!m_full || (ov && bus.out_ready)));
            chk("model RA", bus.RA, m_ra);
            chk("model RB", bus.RB, m_rb);
            chk("model I", 32'(bus.I), 32'(m_i));
            chk("model S", 32'(bus.S), 32'(m_s));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_ra = 0; bus.in_rb = 0; bus.in_ra_idx = 0; bus.in_rb_idx = 0;
        bus.in_i = 0; bus.in_s = 0;
        bus.ex_we = 0; bus.ex_rd = 0; bus.ex_data = 0; bus.ex_is_load = 0;
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.flush = 0;
        bus.out_ready = 1;
    endtask

    task automatic offer(input logic [31:0] ra, input logic [4:0] ra_idx,
                         input logic [31:0] rb, input logic [4:0] rb_idx,
                         input logic [20:0] i, input logic [2:0] s);
        bus.in_valid = 1; bus.in_ra = ra; bus.in_ra_idx = ra_idx;
        bus.in_rb = rb; bus.in_rb_idx = rb_idx; bus.in_i = i; bus.in_s = s;
    endtask

    initial begin
        idle();
        reset = 1;
        cyc(); cyc();
        chk("reset out_valid", 32'(bus.out_valid), 0);
        chk("reset RA", bus.RA, 0);
        chk("reset RB", bus.RB, 0);
        chk("reset I", 32'(bus.I), 0);
        chk("reset S", 32'(bus.S), 0);
        reset = 0;
        cyc();
        chk("post-reset in_ready", 32'(bus.in_ready), 1);

        // plain capture, no forwarding
        offer(32'h12345678, 5'd3, 32'h84031FEB, 5'd4, 21'h1ABCD, 3'd5);
        cyc();
        chk("cap out_valid", 32'(bus.out_valid), 1);
        chk("cap RB", bus.RB, 32'h84031FEB);
        chk("cap RA", bus.RA, 32'h12345678);
        chk("cap I", 32'(bus.I), 32'h1ABCD);
        chk("cap S", 32'(bus.S), 5);

        // EX beats WB; index 0 never forwarded; WB alone
        offer(32'h00000005, 5'd0, 32'hAAAA0000, 5'd7, 21'h00011, 3'd1);
        bus.ex_we = 1; bus.ex_rd = 7; bus.ex_data = 32'h11111111;
        bus.wb_we = 1; bus.wb_rd = 7; bus.wb_data = 32'h22222222;
        cyc();
        chk("ex-over-wb RB", bus.RB, 32'h11111111);
        chk("idx0 RA", bus.RA, 32'h00000005);
        chk("b2b out_valid", 32'(bus.out_valid), 1);
        bus.in_rb_idx = 0;
        cyc();
        chk("idx0 RB", bus.RB, 32'hAAAA0000);
        bus.in_rb_idx = 7; bus.ex_we = 0;
        cyc();
        chk("wb-only RB", bus.RB, 32'h22222222);
        idle();
        cyc();
        chk("drain out_valid", 32'(bus.out_valid), 0);

        // load-use: pending until WB supplies the value
        offer(32'h0BAD0000, 5'd5, 32'h0, 5'd0, 21'h0, 3'd0);
        bus.ex_we = 1; bus.ex_rd = 5; bus.ex_is_load = 1; bus.ex_data = 32'h99999999;
        cyc();
        chk("load-use out_valid", 32'(bus.out_valid), 0);
        chk("load-use in_ready", 32'(bus.in_ready), 0);
        idle();
        bus.wb_we = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF;
        cyc();
        chk("load-fill out_valid", 32'(bus.out_valid), 1);
        chk("load-fill RA", bus.RA, 32'hDEADBEEF);
        idle();
        cyc();

        // backpressure: held stable, then back-to-back capture
        bus.out_ready = 0;
        offer(32'h01010101, 5'd1, 32'h02020202, 5'd2, 21'h0AAAA, 3'd2);
        cyc();
        offer(32'h03030303, 5'd1, 32'h04040404, 5'd2, 21'h05555, 3'd6);
        for (int k = 0; k < 3; k++) begin
            chk("stall RA", bus.RA, 32'h01010101);
            chk("stall RB", bus.RB, 32'h02020202);
            chk("stall in_ready", 32'(bus.in_ready), 0);
            cyc();
        end
        bus.out_ready = 1;
        cyc();
        chk("no-bubble out_valid", 32'(bus.out_valid), 1);
        chk("no-bubble RA", bus.RA, 32'h03030303);
        chk("no-bubble S", 32'(bus.S), 6);
        idle();
        cyc();

        // flush while full with a new offer
        bus.out_ready = 0;
        offer(32'h55555555, 5'd9, 32'h66666666, 5'd10, 21'h1, 3'd3);
        cyc();
        offer(32'h77777777, 5'd11, 32'h88888888, 5'd12, 21'h2, 3'd4);
        bus.flush = 1;
        cyc();
        chk("flush out_valid", 32'(bus.out_valid), 0);
        chk("flush in_ready", 32'(bus.in_ready), 1);
        idle();
        bus.out_ready = 0;

        // reset in the middle of a hold
        offer(32'hCAFEF00D, 5'd13, 32'hFEEDFACE, 5'd14, 21'h1FFFF, 3'd7);
        cyc();
        chk("hold out_valid", 32'(bus.out_valid), 1);
        bus.in_valid = 0;
        reset = 1;
        cyc();
        chk("midreset out_valid", 32'(bus.out_valid), 0);
        chk("midreset RA", bus.RA, 0);
        chk("midreset RB", bus.RB, 0);
        chk("midreset I", 32'(bus.I), 0);
        chk("midreset S", 32'(bus.S), 0);
        chk("midreset in_ready", 32'(bus.in_ready), 1);
        reset = 0;
        idle();
        cyc();

        // mixed traffic on a few registers, checked by the model
        for (int n = 0; n < 300; n++) begin
            bus.in_valid   = ($urandom_range(0, 2) != 0);
            bus.in_ra      = $urandom;
            bus.in_rb      = $urandom;
            bus.in_ra_idx  = 5'($urandom_range(0, 3));
            bus.in_rb_idx  = 5'($urandom_range(0, 3));
            bus.in_i       = 21'($urandom);
            bus.in_s       = 3'($urandom);
            bus.ex_we      = ($urandom_range(0, 1) != 0);
            bus.ex_rd      = 5'($urandom_range(0, 3));
            bus.ex_data    = $urandom;
            bus.ex_is_load = ($urandom_range(0, 3) == 0);
            bus.wb_we      = ($urandom_range(0, 1) != 0);
            bus.wb_rd      = 5'($urandom_range(0, 3));
            bus.wb_data    = $urandom;
            bus.flush      = ($urandom_range(0, 15) == 0);
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle();
        cyc(); cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
